// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: steps or branches the PC, handles stall/halt,
// runs an IDLE/RUN/DONE start-done handshake and keeps saturating run statistics.
module pc_fetch_unit #(
    parameter int                PC_W       = 12,
    parameter logic [PC_W-1:0]   START_ADDR = 12'd0,
    parameter logic [PC_W-1:0]   PROG_END   = 12'd4095,
    parameter int                ICNT_W     = 16,
    parameter int                TCNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              halt,
    input  logic              branch_req,
    input  logic              branch_cond,
    input  logic [PC_W-1:0]   branch_pos,
    output logic              branch_lut_en,
    output logic [PC_W-1:0]   pc,
    output logic              running,
    output logic              done,
    output logic [ICNT_W-1:0] instr_count,
    output logic [TCNT_W-1:0] taken_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [PC_W-1:0]   pc_nx;
    logic [ICNT_W-1:0] icnt_nx;
    logic [TCNT_W-1:0] tcnt_nx;

    function automatic logic [ICNT_W-1:0] sat_inc_icnt(input logic [ICNT_W-1:0] v);
        return (&v) ? v : v + ICNT_W'(1);
    endfunction

    function automatic logic [TCNT_W-1:0] sat_inc_tcnt(input logic [TCNT_W-1:0] v);
        return (&v) ? v : v + TCNT_W'(1);
    endfunction

    assign running = (state == RUN);
    assign done    = (state == DONE);

    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        icnt_nx       = instr_count;
        tcnt_nx       = taken_count;
        branch_lut_en = (state == RUN) & ~stall & ~halt & branch_req & branch_cond;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = RUN;
                    pc_nx    = START_ADDR;
                    icnt_nx  = '0;
                    tcnt_nx  = '0;
                end
            end
            RUN: begin
                // Priority order: stall > halt > taken branch > end of program > step.
                if (stall) begin
                    state_nx = RUN;
                end else if (halt) begin
                    state_nx = DONE;
                    icnt_nx  = sat_inc_icnt(instr_count);
                end else if (branch_lut_en) begin
                    pc_nx   = branch_pos;
                    icnt_nx = sat_inc_icnt(instr_count);
                    tcnt_nx = sat_inc_tcnt(taken_count);
                end else if (pc == PROG_END) begin
                    state_nx = DONE;
                    icnt_nx  = sat_inc_icnt(instr_count);
                end else begin
                    pc_nx   = pc + PC_W'(1);
                    icnt_nx = sat_inc_icnt(instr_count);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= START_ADDR;
            instr_count <= '0;
            taken_count <= '0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            instr_count <= icnt_nx;
            taken_count <= tcnt_nx;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: vector table plus hand sequences, expected values queued
// per driven cycle and compared once the clock edge has produced the DUT response.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic        halt;
    logic        branch_req;
    logic        branch_cond;
    logic [11:0] branch_pos;

    logic        lut_a, run_a, done_a;
    logic [11:0] pc_a;
    logic [15:0] icnt_a;
    logic [7:0]  tcnt_a;

    logic        lut_b, run_b, done_b;
    logic [11:0] pc_b;
    logic [15:0] icnt_b;
    logic [7:0]  tcnt_b;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
        .branch_req(branch_req), .branch_cond(branch_cond), .branch_pos(branch_pos),
        .branch_lut_en(lut_a), .pc(pc_a), .running(run_a), .done(done_a),
        .instr_count(icnt_a), .taken_count(tcnt_a)
    );

    // Short-program build so the end-of-program path is reachable.
    pc_fetch_unit #(.PROG_END(12'd10)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
        .branch_req(branch_req), .branch_cond(branch_cond), .branch_pos(branch_pos),
        .branch_lut_en(lut_b), .pc(pc_b), .running(run_b), .done(done_b),
        .instr_count(icnt_b), .taken_count(tcnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [11:0] pc;
        logic        run;
        logic        done;
        logic [15:0] icnt;
        logic [7:0]  tcnt;
    } exp_t;

    typedef struct {
        logic        start, stall, halt, breq, bcond;
        logic [11:0] bpos;
        logic        lut;
        exp_t        e;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    function automatic exp_t ex(input logic [11:0] p, input logic r, input logic d,
                                input logic [15:0] ic, input logic [7:0] tc);
        exp_t t;
        t.pc = p; t.run = r; t.done = d; t.icnt = ic; t.tcnt = tc;
        return t;
    endfunction

    function automatic vec_t mk(input logic st, input logic stl, input logic hl,
                                input logic br, input logic bc, input logic [11:0] bp,
                                input logic lut, input exp_t e);
        vec_t v;
        v.start = st; v.stall = stl; v.halt = hl; v.breq = br; v.bcond = bc;
        v.bpos = bp; v.lut = lut; v.e = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic set_in(input logic st, input logic stl, input logic hl,
                          input logic br, input logic bc, input logic [11:0] bp);
        start = st; stall = stl; halt = hl; branch_req = br; branch_cond = bc; branch_pos = bp;
    endtask

    // Entered at posedge+1: drive, check the combinational enable, then check post-edge state.
    task automatic step(input logic st, input logic stl, input logic hl, input logic br,
                        input logic bc, input logic [11:0] bp, input logic e_lut, input exp_t e);
        exp_t g;
        set_in(st, stl, hl, br, bc, bp);
        #2;
        check("branch_lut_en", {31'd0, lut_a}, {31'd0, e_lut});
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        check("pc", {20'd0, pc_a}, {20'd0, g.pc});
        check("running", {31'd0, run_a}, {31'd0, g.run});
        check("done", {31'd0, done_a}, {31'd0, g.done});
        check("instr_count", {16'd0, icnt_a}, {16'd0, g.icnt});
        check("taken_count", {24'd0, tcnt_a}, {24'd0, g.tcnt});
    endtask

    task automatic tick(input logic st, input logic hl, input logic br, input logic bc,
                        input logic [11:0] bp);
        set_in(st, 1'b0, hl, br, bc, bp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        #1;
        do_reset();

        // Reset state, with a would-be taken branch presented while IDLE.
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'd77);
        #2;
        check("reset pc", {20'd0, pc_a}, 32'd0);
        check("reset running", {31'd0, run_a}, 32'd0);
        check("reset done", {31'd0, done_a}, 32'd0);
        check("reset instr_count", {16'd0, icnt_a}, 32'd0);
        check("reset taken_count", {24'd0, tcnt_a}, 32'd0);
        check("reset lut_en idle", {31'd0, lut_a}, 32'd0);
        @(posedge clk);
        #1;

        // Sequential run to a halt at pc=5, branch taken/not taken, stall over halt+branch.
        vecs.push_back(mk(1, 0, 0, 1, 1, 12'd77,  0, ex(12'd0,   1, 0, 16'd0,  8'd0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 12'd0,   0, ex(12'd1,   1, 0, 16'd1,  8'd0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 12'd0,   0, ex(12'd2,   1, 0, 16'd2,  8'd0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 12'd0,   0, ex(12'd3,   1, 0, 16'd3,  8'd0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 12'd0,   0, ex(12'd4,   1, 0, 16'd4,  8'd0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 12'd0,   0, ex(12'd5,   1, 0, 16'd5,  8'd0)));
        vecs.push_back(mk(0, 0, 1, 0, 0, 12'd0,   0, ex(12'd5,   0, 1, 16'd6,  8'd0)));
        vecs.push_back(mk(0, 0, 0, 1, 1, 12'd99,  0, ex(12'd5,   0, 1, 16'd6,  8'd0)));
        vecs.push_back(mk(1, 0, 0, 0, 0, 12'd0,   0, ex(12'd0,   1, 0, 16'd0,  8'd0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 12'd0,   0, ex(12'd1,   1, 0, 16'd1,  8'd0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 12'd0,   0, ex(12'd2,   1, 0, 16'd2,  8'd0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 12'd0,   0, ex(12'd3,   1, 0, 16'd3,  8'd0)));
        vecs.push_back(mk(0, 0, 0, 1, 1, 12'd108, 1, ex(12'd108, 1, 0, 16'd4,  8'd1)));
        vecs.push_back(mk(0, 0, 0, 1, 1, 12'd3,   1, ex(12'd3,   1, 0, 16'd5,  8'd2)));
        vecs.push_back(mk(0, 0, 0, 1, 0, 12'd108, 0, ex(12'd4,   1, 0, 16'd6,  8'd2)));
        vecs.push_back(mk(1, 0, 0, 0, 0, 12'd0,   0, ex(12'd5,   1, 0, 16'd7,  8'd2)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 12'd0,   0, ex(12'd6,   1, 0, 16'd8,  8'd2)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 12'd0,   0, ex(12'd7,   1, 0, 16'd9,  8'd2)));
        vecs.push_back(mk(1, 1, 1, 1, 1, 12'd200, 0, ex(12'd7,   1, 0, 16'd9,  8'd2)));
        vecs.push_back(mk(1, 1, 1, 1, 1, 12'd200, 0, ex(12'd7,   1, 0, 16'd9,  8'd2)));
        vecs.push_back(mk(1, 1, 1, 1, 1, 12'd200, 0, ex(12'd7,   1, 0, 16'd9,  8'd2)));
        vecs.push_back(mk(0, 0, 1, 1, 1, 12'd200, 0, ex(12'd7,   0, 1, 16'd10, 8'd2)));
        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].start, vecs[i].stall, vecs[i].halt, vecs[i].breq, vecs[i].bcond,
                 vecs[i].bpos, vecs[i].lut, vecs[i].e);

        // End-of-program build: retire pc=10 then stop; branch at pc=10 keeps running.
        do_reset();
        tick(1, 0, 0, 0, 12'd0);
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 0, 12'd0);
        check("pend pc at end", {20'd0, pc_b}, 32'd10);
        check("pend running at end", {31'd0, run_b}, 32'd1);
        tick(0, 0, 0, 0, 12'd0);
        check("pend done", {31'd0, done_b}, 32'd1);
        check("pend pc held", {20'd0, pc_b}, 32'd10);
        check("pend instr_count", {16'd0, icnt_b}, 32'd11);
        tick(1, 0, 0, 0, 12'd0);
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 0, 12'd0);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'd4);
        #2;
        check("pend branch lut_en", {31'd0, lut_b}, 32'd1);
        @(posedge clk);
        #1;
        check("pend branch pc", {20'd0, pc_b}, 32'd4);
        check("pend branch running", {31'd0, run_b}, 32'd1);
        check("pend branch done", {31'd0, done_b}, 32'd0);
        check("pend branch taken_count", {24'd0, tcnt_b}, 32'd1);
        tick(0, 0, 0, 0, 12'd0);
        check("pend continue pc", {20'd0, pc_b}, 32'd5);

        // Tight loop at pc=2 for 300 taken branches: taken_count saturates.
        do_reset();
        step(1, 0, 0, 0, 0, 12'd0, 0, ex(12'd0, 1, 0, 16'd0, 8'd0));
        step(0, 0, 0, 0, 0, 12'd0, 0, ex(12'd1, 1, 0, 16'd1, 8'd0));
        step(0, 0, 0, 0, 0, 12'd0, 0, ex(12'd2, 1, 0, 16'd2, 8'd0));
        for (int k = 1; k <= 300; k++)
            step(0, 0, 0, 1, 1, 12'd2, 1,
                 ex(12'd2, 1, 0, 16'(2 + k), (k > 255) ? 8'd255 : 8'(k)));
        step(0, 0, 1, 1, 1, 12'd9, 0, ex(12'd2, 0, 1, 16'd303, 8'd255));
        step(1, 0, 0, 0, 0, 12'd0, 0, ex(12'd0, 1, 0, 16'd0, 8'd0));

        // Asynchronous reset between edges, with a taken branch target zero on the way.
        do_reset();
        step(1, 0, 0, 0, 0, 12'd0,  0, ex(12'd0,  1, 0, 16'd0, 8'd0));
        step(0, 0, 0, 1, 1, 12'd50, 1, ex(12'd50, 1, 0, 16'd1, 8'd1));
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async pc", {20'd0, pc_a}, 32'd0);
        check("async running", {31'd0, run_a}, 32'd0);
        check("async done", {31'd0, done_a}, 32'd0);
        check("async instr_count", {16'd0, icnt_a}, 32'd0);
        check("async taken_count", {24'd0, tcnt_a}, 32'd0);
        check("async lut_en", {31'd0, lut_a}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 12'd0, 0, ex(12'd0, 0, 0, 16'd0, 8'd0));
        step(1, 0, 0, 0, 0, 12'd0, 0, ex(12'd0, 1, 0, 16'd0, 8'd0));
        step(0, 0, 0, 0, 0, 12'd0, 0, ex(12'd1, 1, 0, 16'd1, 8'd0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
